// File: rtl/cla_serial_adder.sv
// cla_serial_adder: WIDTH-bit add/subtract built around a single 4-bit
// carry-lookahead slice. The slice is time-multiplexed over the operand one
// nibble per cycle, LSB first, with the carry chained through a flop.
// Valid/ready handshake on both sides; result registers hold the last result.
module cla_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 4-bit carry-lookahead slice. Returns {carry_out, carry_into_bit3, sum[3:0]};
  // the carry into bit 3 is kept so the top nibble can form the signed
  // overflow flag without a second adder.
  function automatic logic [5:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       c4;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, c[3], p ^ c};
  endfunction

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;
  logic               carry_q,    carry_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic               zero_acc_q, zero_acc_d;
  logic [WIDTH-1:0]   sum_q,      sum_d;
  logic               cout_q,     cout_d;
  logic               overflow_q, overflow_d;
  logic               zero_q,     zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0]         a_nib_s;
  logic [3:0]         b_nib_s;
  logic [5:0]         slice_s;
  logic [3:0]         slice_sum_s;
  logic               slice_cout_s;
  logic               slice_c3_s;
  logic               slice_zero_s;

  // Select the active nibble of each latched operand and run it through the slice.
  always_comb begin
    a_nib_s      = a_q[{idx_q, 2'b00} +: 4];
    b_nib_s      = b_q[{idx_q, 2'b00} +: 4];
    slice_s      = cla4(a_nib_s, b_nib_s, carry_q);
    slice_sum_s  = slice_s[3:0];
    slice_c3_s   = slice_s[4];
    slice_cout_s = slice_s[5];
    slice_zero_s = (slice_sum_s == 4'd0);
  end

  // Next-state and datapath update: latch on accept, step one nibble per RUN cycle.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    zero_acc_d = zero_acc_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub;
          idx_d      = {IDX_W{1'b0}};
          zero_acc_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_sum_s;
        carry_d    = slice_cout_s;
        zero_acc_d = zero_acc_q & slice_zero_s;
        if (idx_q == LAST_IDX) begin
          cout_d     = slice_cout_s;
          overflow_d = slice_c3_s ^ slice_cout_s;
          zero_d     = zero_acc_q & slice_zero_s;
          state_d    = ST_DONE;
        end else begin
          idx_d      = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and result registers; reset aborts any op and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      zero_acc_q  <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      zero_acc_q  <= zero_acc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed self-checking bench for cla_serial_adder (WIDTH=32).
module tb_cla_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  int vectors;
  int miscompares;

  cla_serial_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands, accept at the next edge, then wait for out_valid and
  // check latency plus all result fields. Leaves the unit in DONE.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez);
    int lat;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; sub = ~sv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"},  lat,               32'd8);
    chk({tag, "_sum"},      sum,               es);
    chk({tag, "_cout"},     {31'd0, cout},     {31'd0, ec});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_zero"},     {31'd0, zero},     {31'd0, ez});
  endtask

  // Complete the output handshake and check the unit is back in IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ir"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       sum,                32'd0);
    chk("rst_flags",     {29'd0, cout, overflow, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. basic add
    run_op("add5_3", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
    drain("add5_3");
    // 2. signed overflow on add
    run_op("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drain("ovf_add");
    // 3. full carry ripple to zero
    run_op("wrap_add", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    drain("wrap_add");
    // 4. subtraction: equal operands, borrow, signed overflow
    run_op("sub5_5", 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    drain("sub5_5");
    run_op("sub3_5", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    drain("sub3_5");
    run_op("ovf_sub", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drain("ovf_sub");

    // 5. backpressure in DONE with new operands pending
    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    a = 32'h10; b = 32'h20; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ov",  {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ir",  {31'd0, in_ready},  32'd0);
      chk("bp_hold_sum", sum,                32'h2345_6789);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_after_ir", {31'd0, in_ready},  32'd1);
    chk("bp_keep_sum", sum,                32'h2345_6789);
    run_op("bp_next", 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0);
    drain("bp_next");

    // 6. reset mid-RUN aborts the op
    a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ov",   {31'd0, out_valid}, 32'd0);
    chk("midrst_ir",   {31'd0, in_ready},  32'd1);
    chk("midrst_sum",  sum,                32'd0);
    chk("midrst_flag", {29'd0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_ov",  {31'd0, out_valid}, 32'd0);
    chk("postrst_sum", sum,                32'd0);
    run_op("post_1_1", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    drain("post_1_1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
